dmem_responder: RTL and testbench

- Memory-side responder for core load/store traffic: accepts one request at a time over a valid/ready request channel, inserts a fixed number of wait states, and returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency combinational data memory when the core moves to a handshaked, multi-cycle memory interface.
- Word-organised RAM with byte-lane write strobes and error reporting for misaligned or out-of-range addresses.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// One request is accepted over a valid/ready channel. After WAIT_CYCLES wait
// states, a store is committed or a load word is registered, and then returned
// over a valid/ready response channel. Misaligned and out-of-range accesses are
// flagged on rsp_error and never touch the RAM.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | req_ready high, waiting for a request
//   WAIT   | request latched, counting down the wait states
//   RESP   | response registered, held until rsp_ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          use_live;
  logic          dec_write;
  logic [31:0]   dec_addr;
  logic [31:0]   dec_wdata;
  logic [3:0]    dec_wstrb;
  logic          dec_err;
  logic [AW-1:0] dec_idx;
  logic          to_resp;
  logic          mem_we;
  logic [31:0]   rdata_d;

  // Pick the access to decode: with no wait states the live request goes
  // straight to RESP, otherwise the latched copy is used.
  always_comb begin
    use_live  = (state_q == S_IDLE);
    dec_write = use_live ? req_write : write_q;
    dec_addr  = use_live ? req_addr  : addr_q;
    dec_wdata = use_live ? req_wdata : wdata_q;
    dec_wstrb = use_live ? req_wstrb : wstrb_q;
  end

  // Address decode; the range check is done in 33 bits so the top of the
  // window never wraps. BASE_ADDR is window-aligned, so its index bits are 0.
  always_comb begin
    dec_err = (dec_addr[1:0] != 2'b00)
            | ({1'b0, dec_addr} < {1'b0, BASE_ADDR})
            | ({1'b0, dec_addr} >= LIMIT);
    dec_idx = dec_addr[AW+1:2] - BASE_ADDR[AW+1:2];
  end

  // Edge on which the FSM enters RESP: commit store / capture load here.
  always_comb begin
    to_resp = 1'b0;
    if (state_q == S_IDLE && req_valid && ZERO_WAIT) to_resp = 1'b1;
    if (state_q == S_WAIT && cnt_q == 4'd1)          to_resp = 1'b1;
    // Gate with reset so nothing live can slip into RAM while held in reset.
    mem_we  = to_resp & dec_write & ~dec_err & reset;
    rdata_d = (dec_write || dec_err) ? 32'h0 : mem[dec_idx];
  end

  // RAM with byte-lane strobes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dec_wstrb[i]) mem[dec_idx][8*i +: 8] <= dec_wdata[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            cnt_q       <= WAIT_INIT;
            req_ready_q <= 1'b0;
            if (ZERO_WAIT) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_error_q <= dec_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_error_q <= dec_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses 2 wait states, instance 1
// uses none. Both share the request payload and reset; valid/ready are separate.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_error;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance sel and wait for its response.
  // lat = number of falling edges after the accept edge until rsp_valid is seen.
  task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_write      = wr;
    req_addr       = addr;
    req_wdata      = wdata;
    req_wstrb      = strb;
    req_valid[sel] = 1'b1;
    rsp_ready[sel] = 1'b1;
    chk("req_ready_before_accept", 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 1;
    while (!rsp_valid[sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[sel];
    er = rsp_error[sel];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'h0);
    chk("reset_rsp_error", 32'(rsp_error[0]), 32'd0);
    reset = 1'b1;

    // store then load, latency W+1 = 3
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("store10_latency", 32'(lat), 32'd3);
    chk("store10_error", 32'(er), 32'd0);
    chk("store10_rdata", rd, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("load10_latency", 32'(lat), 32'd3);
    chk("load10_rdata", rd, 32'hDEADBEEF);
    chk("load10_error", 32'(er), 32'd0);

    // byte strobes
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    chk("strobe_store_error", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("load20_strobed", rd, 32'h11BB33DD);

    // zero strobe: normal response, RAM unchanged
    do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("zero_strobe_error", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("zero_strobe_unchanged", rd, 32'h11BB33DD);

    // misaligned load
    do_req(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("misaligned_error", 32'(er), 32'd1);
    chk("misaligned_rdata", rd, 32'h0);

    // out-of-range store must not alias onto word 0
    do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_req(0, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
    chk("oor_store_error", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'hFFFFFFFC, 32'h87654321, 4'hF, rd, er, lat);
    chk("top_addr_error", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("word0_unchanged", rd, 32'hCAFEF00D);

    // last word in range
    do_req(0, 1'b1, 32'h3FC, 32'h0F0F0F0F, 4'hF, rd, er, lat);
    chk("last_word_store_error", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    chk("last_word_load", rd, 32'h0F0F0F0F);

    // backpressure on a load of 0x10, with ignored store pulses to 0x20
    @(negedge clk);
    req_write    = 1'b0;
    req_addr     = 32'h10;
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      req_write    = 1'b1;
      req_addr     = 32'h20;
      req_wdata    = 32'h0;
      req_wstrb    = 4'hF;
      req_valid[0] = (i % 2 == 0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    chk("bp_rdata_before_handshake", rsp_rdata[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("bp_req_ready_after", 32'(req_ready[0]), 32'd1);
    chk("bp_rsp_valid_after", 32'(rsp_valid[0]), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'h11BB33DD);

    // zero-wait instance
    do_req(1, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, rd, er, lat);
    chk("w0_store_latency", 32'(lat), 32'd1);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_rdata", rd, 32'h0BADCAFE);
    @(negedge clk);
    req_write    = 1'b0;
    req_addr     = 32'h8;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid[1]) n++;
    end
    req_valid[1] = 1'b0;
    chk("w0_streaming_responses", 32'(n), 32'd5);
    @(negedge clk);

    // reset while a store sits in WAIT
    do_req(0, 1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req_write    = 1'b1;
    req_addr     = 32'h30;
    req_wdata    = 32'h55AA55AA;
    req_wstrb    = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_release_rsp_rdata", rsp_rdata[0], 32'h0);
    chk("rst_release_rsp_error", 32'(rsp_error[0]), 32'd0);
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("rst_store_not_committed", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
